// File: rtl/store_queue_pkg.sv
// Shared constants for the store queue: store opcodes, default depth and the store-size encoding.
package store_queue_pkg;

   localparam int SQ_OPCODE_WIDTH = 6;
   localparam int SQ_DEPTH        = 4;

   localparam logic [SQ_OPCODE_WIDTH-1:0] OP_STORE      = 6'h2B;
   localparam logic [SQ_OPCODE_WIDTH-1:0] OP_STORE_HALF = 6'h29;
   localparam logic [SQ_OPCODE_WIDTH-1:0] OP_STORE_BYTE = 6'h28;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } store_size_e;

endpackage

// File: rtl/store_align.sv
// Combinational store formatter: opcode + lane offset -> lane-placed data, byte mask, misalign flag.
module store_align
   import store_queue_pkg::*;
#(
   parameter int DWIDTH       = 32,
   parameter int OPCODE_WIDTH = SQ_OPCODE_WIDTH,
   parameter int LANES        = DWIDTH / 8,
   parameter int OFFW         = $clog2(DWIDTH / 8)
) (
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [OFFW-1:0]         i_off,
   input  logic [DWIDTH-1:0]       i_data,
   output logic                    o_is_store,
   output logic                    o_misalign,
   output logic [DWIDTH-1:0]       o_data,
   output logic [LANES-1:0]        o_mask
);

   store_size_e       w_size;
   logic [LANES-1:0]  w_base_mask;
   logic [DWIDTH-1:0] w_base_data;

   always_comb begin
      w_size = SZ_NONE;
      if (i_opcode == OPCODE_WIDTH'(OP_STORE_BYTE))
         w_size = SZ_BYTE;
      else if (i_opcode == OPCODE_WIDTH'(OP_STORE_HALF))
         w_size = SZ_HALF;
      else if (i_opcode == OPCODE_WIDTH'(OP_STORE))
         w_size = SZ_WORD;
   end

   // Value sits in the low bits; build it at lane 0 first, then shift to the addressed lane.
   always_comb begin
      w_base_mask = '0;
      w_base_data = '0;
      o_misalign  = 1'b0;
      case (w_size)
         SZ_BYTE: begin
            w_base_mask = LANES'(1);
            w_base_data = DWIDTH'(i_data[7:0]);
         end
         SZ_HALF: begin
            w_base_mask = LANES'(2'b11);
            w_base_data = DWIDTH'(i_data[15:0]);
            o_misalign  = i_off[0];
         end
         SZ_WORD: begin
            w_base_mask = LANES'(4'hF);
            w_base_data = DWIDTH'(i_data[31:0]);
            o_misalign  = |i_off[1:0];
         end
         default: ;
      endcase
   end

   assign o_is_store = (w_size != SZ_NONE);
   assign o_mask     = w_base_mask << i_off;
   assign o_data     = w_base_data << {i_off, 3'b000};

endmodule

// File: rtl/store_queue.sv
// Store queue: formats MEM-stage stores into lane data/mask and buffers them in a DEPTH-entry FIFO.
// Optional load-hazard comparators are built when the SQ_LD_CHECK_EN macro is defined.
module store_queue
   import store_queue_pkg::*;
#(
   parameter int DWIDTH       = 32,
   parameter int AWIDTH       = 32,
   parameter int DEPTH        = SQ_DEPTH,
   parameter int OPCODE_WIDTH = SQ_OPCODE_WIDTH
) (
   input  logic                      sq_i_clk,
   input  logic                      sq_i_rst_n,
   input  logic                      sq_i_valid,
   output logic                      sq_o_ready,
   input  logic [OPCODE_WIDTH-1:0]   sq_i_opcode,
   input  logic [AWIDTH-1:0]         sq_i_addr,
   input  logic [DWIDTH-1:0]         sq_i_data,
   output logic                      sq_o_misalign,
   output logic                      sq_o_mem_valid,
   input  logic                      sq_i_mem_ready,
   output logic [AWIDTH-1:0]         sq_o_mem_addr,
   output logic [DWIDTH-1:0]         sq_o_mem_data,
   output logic [DWIDTH/8-1:0]       sq_o_mem_mask,
   output logic                      sq_o_empty,
   output logic [$clog2(DEPTH):0]    sq_o_count
`ifdef SQ_LD_CHECK_EN
   ,
   input  logic                      sq_i_ld_valid,
   input  logic [AWIDTH-1:0]         sq_i_ld_addr,
   output logic                      sq_o_ld_hit
`endif
);

   localparam int LANES = DWIDTH / 8;
   localparam int OFFW  = $clog2(LANES);
   localparam int PTRW  = $clog2(DEPTH);
   localparam int CW    = PTRW + 1;

   logic [AWIDTH-1:0] r_addr [DEPTH];
   logic [DWIDTH-1:0] r_data [DEPTH];
   logic [LANES-1:0]  r_mask [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [PTRW-1:0]   r_wr_ptr;
   logic [PTRW-1:0]   r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_misalign;

   logic              w_is_store;
   logic              w_misalign;
   logic [DWIDTH-1:0] w_lane_data;
   logic [LANES-1:0]  w_lane_mask;
   logic [AWIDTH-1:0] w_word_addr;
   logic              w_full;
   logic              w_accept;
   logic              w_enq;
   logic              w_deq;

   store_align #(
      .DWIDTH       (DWIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_align (
      .i_opcode   (sq_i_opcode),
      .i_off      (sq_i_addr[OFFW-1:0]),
      .i_data     (sq_i_data),
      .o_is_store (w_is_store),
      .o_misalign (w_misalign),
      .o_data     (w_lane_data),
      .o_mask     (w_lane_mask)
   );

   assign w_word_addr = {sq_i_addr[AWIDTH-1:OFFW], OFFW'(0)};
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_accept    = sq_i_valid & ~w_full;
   assign w_enq       = w_accept & w_is_store & ~w_misalign;
   assign w_deq       = sq_o_mem_valid & sq_i_mem_ready;

   always_ff @(posedge sq_i_clk) begin
      if (!sq_i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
         r_valid    <= '0;
      end else begin
         r_misalign <= w_accept & w_is_store & w_misalign;
         // Enqueue needs !full and dequeue needs !empty, so both slots differ when both fire.
         if (w_enq) begin
            r_wr_ptr           <= r_wr_ptr + 1'b1;
            r_valid[r_wr_ptr]  <= 1'b1;
         end
         if (w_deq) begin
            r_rd_ptr           <= r_rd_ptr + 1'b1;
            r_valid[r_rd_ptr]  <= 1'b0;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; entry validity lives in r_valid.
   always_ff @(posedge sq_i_clk) begin
      if (w_enq) begin
         r_addr[r_wr_ptr] <= w_word_addr;
         r_data[r_wr_ptr] <= w_lane_data;
         r_mask[r_wr_ptr] <= w_lane_mask;
      end
   end

   assign sq_o_ready     = ~w_full;
   assign sq_o_empty     = (r_count == '0);
   assign sq_o_count     = r_count;
   assign sq_o_misalign  = r_misalign;
   assign sq_o_mem_valid = r_valid[r_rd_ptr];
   assign sq_o_mem_addr  = sq_o_mem_valid ? r_addr[r_rd_ptr] : '0;
   assign sq_o_mem_data  = sq_o_mem_valid ? r_data[r_rd_ptr] : '0;
   assign sq_o_mem_mask  = sq_o_mem_valid ? r_mask[r_rd_ptr] : '0;

`ifdef SQ_LD_CHECK_EN
   logic [DEPTH-1:0] w_ld_match;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ld_cmp
      assign w_ld_match[gi] = r_valid[gi] &
                              (r_addr[gi][AWIDTH-1:OFFW] == sq_i_ld_addr[AWIDTH-1:OFFW]);
   end

   assign sq_o_ld_hit = sq_i_ld_valid & (|w_ld_match);
`endif

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed vector table, hand-written corner sequences,
// and a randomized run checked against a queue-based reference model.
module tb_store_queue;
   import store_queue_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid;
   logic          ready;
   logic [5:0]    opcode;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          misalign;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [3:0]    mem_mask;
   logic          empty;
   logic [CW-1:0] count;
`ifdef SQ_LD_CHECK_EN
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic          ld_hit;
`endif

   store_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .OPCODE_WIDTH(6)) dut (
      .sq_i_clk       (clk),
      .sq_i_rst_n     (rst_n),
      .sq_i_valid     (valid),
      .sq_o_ready     (ready),
      .sq_i_opcode    (opcode),
      .sq_i_addr      (addr),
      .sq_i_data      (data),
      .sq_o_misalign  (misalign),
      .sq_o_mem_valid (mem_valid),
      .sq_i_mem_ready (mem_ready),
      .sq_o_mem_addr  (mem_addr),
      .sq_o_mem_data  (mem_data),
      .sq_o_mem_mask  (mem_mask),
      .sq_o_empty     (empty),
      .sq_o_count     (count)
`ifdef SQ_LD_CHECK_EN
      ,
      .sq_i_ld_valid  (ld_valid),
      .sq_i_ld_addr   (ld_addr),
      .sq_o_ld_hit    (ld_hit)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic        en;
      logic        mis;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_mask;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } ent_t;

   vec_t       vt [9];
   ent_t       mq [$];
   logic [5:0] ops [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference formatting from the byte-lane rules, using plain arithmetic.
   function automatic void ref_store(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] d, output bit st, output bit ok,
                                     output ent_t e);
      int          n;
      int          off;
      logic [63:0] tmp;
      off = int'(a % 4);
      n   = (op == OP_STORE) ? 4 : (op == OP_STORE_HALF) ? 2 : (op == OP_STORE_BYTE) ? 1 : 0;
      st  = (n != 0);
      ok  = st ? ((off % n) == 0) : 1'b0;
      e.a = a - 32'(off);
      e.m = 4'(((1 << n) - 1) << off);
      tmp = (64'(d) & ((64'h1 << (8 * n)) - 64'h1)) << (8 * off);
      e.d = tmp[31:0];
   endfunction

   initial begin
      bit   st;
      bit   ok;
      bit   acc;
      bit   deq;
      logic exp_mis;
      ent_t e;

      ops = '{OP_STORE, OP_STORE_HALF, OP_STORE_BYTE, 6'h00, 6'h3F};
      vt[0] = '{OP_STORE_BYTE, 32'h103, 32'hAB,       1'b1, 1'b0, 32'h100, 32'hAB000000, 4'b1000};
      vt[1] = '{OP_STORE_HALF, 32'h202, 32'h1234,     1'b1, 1'b0, 32'h200, 32'h12340000, 4'b1100};
      vt[2] = '{OP_STORE_HALF, 32'h201, 32'h1234,     1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};
      vt[3] = '{OP_STORE,      32'h300, 32'hDEADBEEF, 1'b1, 1'b0, 32'h300, 32'hDEADBEEF, 4'b1111};
      vt[4] = '{OP_STORE,      32'h302, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};
      vt[5] = '{OP_STORE_BYTE, 32'h100, 32'h55CC,     1'b1, 1'b0, 32'h100, 32'h000000CC, 4'b0001};
      vt[6] = '{OP_STORE_HALF, 32'h020, 32'hFFFF5678, 1'b1, 1'b0, 32'h020, 32'h00005678, 4'b0011};
      vt[7] = '{OP_STORE_BYTE, 32'h007, 32'h12345699, 1'b1, 1'b0, 32'h004, 32'h99000000, 4'b1000};
      vt[8] = '{6'h00,         32'h201, 32'h1234,     1'b0, 1'b0, 32'h0,   32'h0,        4'b0000};

      rst_n = 1'b0; valid = 1'b0; opcode = '0; addr = '0; data = '0; mem_ready = 1'b0;
`ifdef SQ_LD_CHECK_EN
      ld_valid = 1'b0; ld_addr = '0;
`endif
      #1;
      step();
      step();
      chk("rst_ready", ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_mem_mask", mem_mask, 0);
      rst_n = 1'b1;
      step();

      // Directed vectors, one request at a time from an empty queue.
      for (int i = 0; i < 9; i++) begin
         valid = 1'b1; opcode = vt[i].op; addr = vt[i].a; data = vt[i].d;
         step();
         valid = 1'b0;
         chk($sformatf("vec%0d_misalign", i), misalign, vt[i].mis);
         chk($sformatf("vec%0d_count", i), count, vt[i].en);
         chk($sformatf("vec%0d_mem_valid", i), mem_valid, vt[i].en);
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_mem_data", i), mem_data, vt[i].e_data);
         chk($sformatf("vec%0d_mem_mask", i), mem_mask, vt[i].e_mask);
         step();
         chk($sformatf("vec%0d_misalign_pulse_end", i), misalign, 0);
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0;
         chk($sformatf("vec%0d_drained", i), empty, 1);
      end

      // Word store stalled by memory for three cycles.
      valid = 1'b1; opcode = OP_STORE; addr = 32'h300; data = 32'hDEADBEEF;
      step();
      valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall%0d_valid", k), mem_valid, 1);
         chk($sformatf("stall%0d_addr", k), mem_addr, 32'h300);
         chk($sformatf("stall%0d_data", k), mem_data, 32'hDEADBEEF);
         chk($sformatf("stall%0d_mask", k), mem_mask, 4'hF);
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("stall_drained", empty, 1);

      // Fill to DEPTH, then offer a request while full with a dequeue in the same cycle.
      for (int k = 0; k < DEPTH; k++) begin
         valid = 1'b1; opcode = OP_STORE; addr = 32'h1000 + 32'(16 * k); data = 32'hA0 + 32'(k);
         step();
      end
      chk("full_count", count, DEPTH);
      chk("full_ready", ready, 0);
      addr = 32'h2000; mem_ready = 1'b1;
      step();
      valid = 1'b0;
      chk("full_no_enq_count", count, DEPTH - 1);
      for (int k = 1; k < DEPTH; k++) begin
         chk($sformatf("order%0d_addr", k), mem_addr, 32'h1000 + 32'(16 * k));
         chk($sformatf("order%0d_data", k), mem_data, 32'hA0 + 32'(k));
         step();
      end
      chk("order_drained", empty, 1);
      mem_ready = 1'b0;

      // Simultaneous enqueue/dequeue at count 2 across the pointer wrap, then reset mid-drain.
      for (int k = 0; k < 2; k++) begin
         valid = 1'b1; opcode = OP_STORE; addr = 32'h3000 + 32'(16 * k); data = 32'(k);
         step();
      end
      mem_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         addr = 32'h3020 + 32'(16 * k); data = 32'(k + 2);
         step();
         chk($sformatf("simul%0d_count", k), count, 2);
         chk($sformatf("simul%0d_head", k), mem_addr, 32'h3000 + 32'(16 * (k + 1)));
      end
      valid = 1'b0; rst_n = 1'b0;
      step();
      chk("midrst_empty", empty, 1);
      chk("midrst_mem_valid", mem_valid, 0);
      chk("midrst_count", count, 0);
      rst_n = 1'b1; mem_ready = 1'b0;
      step();

`ifdef SQ_LD_CHECK_EN
      valid = 1'b1; opcode = OP_STORE; addr = 32'h400; data = 32'h1;
      step();
      valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h402;
      #1;
      chk("ld_hit_same_word", ld_hit, 1);
      ld_addr = 32'h404;
      #1;
      chk("ld_hit_next_word", ld_hit, 0);
      ld_valid = 1'b0; ld_addr = 32'h400;
      #1;
      chk("ld_hit_no_load", ld_hit, 0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
`endif

      // Randomized run against the reference queue model.
      mq.delete();
      exp_mis = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         chk("rnd_count", count, mq.size());
         chk("rnd_empty", empty, mq.size() == 0);
         chk("rnd_ready", ready, mq.size() < DEPTH);
         chk("rnd_mem_valid", mem_valid, mq.size() != 0);
         chk("rnd_misalign", misalign, exp_mis);
         if (mq.size() != 0) begin
            chk("rnd_mem_addr", mem_addr, mq[0].a);
            chk("rnd_mem_data", mem_data, mq[0].d);
            chk("rnd_mem_mask", mem_mask, mq[0].m);
         end
         valid     = ($urandom_range(0, 9) < 7);
         opcode    = ops[$urandom_range(0, 4)];
         addr      = $urandom;
         data      = $urandom;
         mem_ready = ($urandom_range(0, 9) < (((cyc / 100) % 2 == 1) ? 8 : 3));
         ref_store(opcode, addr, data, st, ok, e);
         acc     = valid && (mq.size() < DEPTH);
         deq     = (mq.size() != 0) && mem_ready;
         exp_mis = acc && st && !ok;
         if (deq) void'(mq.pop_front());
         if (acc && st && ok) mq.push_back(e);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
